// File: rtl/axi_skid_fifo.sv
// Registered-handshake AXI-stream FIFO: m_ready and s_valid come straight from flops.
// Optional occupancy output `level` is enabled by defining AXI_SKID_FIFO_LEVEL_EN.
module axi_skid_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            m_data,
    input  logic                     m_valid,
    output logic                     m_ready,
    output logic [DW-1:0]            s_data,
    output logic                     s_valid,
    input  logic                     s_ready,
    input  logic                     flush
`ifdef AXI_SKID_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push;
    logic          pop;

    assign push   = m_valid & m_ready;
    assign pop    = s_valid & s_ready;
    assign s_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Both handshake flags are computed from the next count so they are valid one
    // cycle after any change, with no combinational path across the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_ready <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_nxt;
            m_ready <= (count_nxt < FULL_CNT);
            s_valid <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= m_data;
        end
    end

`ifdef AXI_SKID_FIFO_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_axi_skid_fifo.sv
// Directed and scoreboarded bench for axi_skid_fifo at DEPTH=2 and DEPTH=4.
// Level checks are compiled in only when AXI_SKID_FIFO_LEVEL_EN is defined.
module tb_axi_skid_fifo;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] a_m_data, a_s_data;
    logic          a_m_valid, a_m_ready, a_s_valid, a_s_ready, a_flush;
    logic [DW-1:0] b_m_data, b_s_data;
    logic          b_m_valid, b_m_ready, b_s_valid, b_s_ready, b_flush;
`ifdef AXI_SKID_FIFO_LEVEL_EN
    logic [1:0]    a_level;
    logic [2:0]    b_level;
`endif

    axi_skid_fifo #(.DW(DW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .flush(a_flush)
`ifdef AXI_SKID_FIFO_LEVEL_EN
        , .level(a_level)
`endif
    );

    axi_skid_fifo #(.DW(DW), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .flush(b_flush)
`ifdef AXI_SKID_FIFO_LEVEL_EN
        , .level(b_level)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int sent, got, last_cyc, acc, n_in, n_out;
    logic [63:0] sb[$];
    logic        prev_stall;
    logic [63:0] prev_data;

    initial begin
        a_m_data = '0; a_m_valid = 1'b0; a_s_ready = 1'b0; a_flush = 1'b0;
        b_m_data = '0; b_m_valid = 1'b0; b_s_ready = 1'b0; b_flush = 1'b0;

        // reset state
        #2;
        check("rst_a_s_valid", a_s_valid, 0);
        check("rst_a_m_ready", a_m_ready, 0);
        check("rst_b_s_valid", b_s_valid, 0);
        check("rst_b_m_ready", b_m_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick;
        check("post_rst_a_m_ready", a_m_ready, 1);
        check("post_rst_b_m_ready", b_m_ready, 1);
        check("post_rst_a_s_valid", a_s_valid, 0);
`ifdef AXI_SKID_FIFO_LEVEL_EN
        check("post_rst_b_level", b_level, 0);
`endif

        // single beat, 1-cycle latency
        a_s_ready = 1'b1;
        a_m_valid = 1'b1;
        a_m_data  = 64'hA5A5_0000_0000_0001;
        tick;
        a_m_valid = 1'b0;
        a_m_data  = '1;
        check("single_s_valid_c1", a_s_valid, 1);
        check("single_s_data_c1", a_s_data, 64'hA5A5_0000_0000_0001);
        tick;
        check("single_s_valid_c2", a_s_valid, 0);

        // streaming 100 beats
        sent = 0; got = 0; last_cyc = -1;
        a_s_ready = 1'b1;
        for (int c = 0; c < 300 && got < 100; c++) begin
            a_m_valid = (sent < 100);
            a_m_data  = 64'h1000 + 64'(sent);
            if (sent < 100) check("stream_m_ready", a_m_ready, 1);
            if (a_s_valid && a_s_ready) begin
                check("stream_data", a_s_data, 64'h1000 + 64'(got));
                got++;
                last_cyc = c;
            end
            if (a_m_valid && a_m_ready) sent++;
            tick;
        end
        a_m_valid = 1'b0;
        check("stream_beats", 64'(got), 100);
        check("stream_last_cycle", 64'(last_cyc), 100);

        // backpressure on DEPTH=4
        acc = 0;
        b_s_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            b_m_valid = 1'b1;
            b_m_data  = 64'(acc + 1);
            if (c >= 1) check("bp_hold_data", b_s_data, 1);
            if (b_m_ready) acc++;
            tick;
        end
        check("bp_accepted", 64'(acc), 4);
        check("bp_m_ready_full", b_m_ready, 0);
        check("bp_s_valid", b_s_valid, 1);
        check("bp_s_data", b_s_data, 1);
`ifdef AXI_SKID_FIFO_LEVEL_EN
        check("bp_level", b_level, 4);
`endif
        b_s_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            b_m_valid = (acc < 6);
            b_m_data  = 64'(acc + 1);
            if (c == 1) check("bp_m_ready_after_pop", b_m_ready, 1);
            if (b_s_valid && b_s_ready) begin
                check("bp_data", b_s_data, 64'(got + 1));
                got++;
            end
            if (b_m_valid && b_m_ready) acc++;
            tick;
        end
        b_m_valid = 1'b0;
        check("bp_beats", 64'(got), 6);
        check("bp_empty_s_valid", b_s_valid, 0);

        // flush with simultaneous push
        b_s_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_m_valid = 1'b1;
            b_m_data  = 64'h7 + 64'(i);
            tick;
        end
        b_m_valid = 1'b0;
        check("fl_pre_s_valid", b_s_valid, 1);
`ifdef AXI_SKID_FIFO_LEVEL_EN
        check("fl_pre_level", b_level, 3);
`endif
        b_flush   = 1'b1;
        b_m_valid = 1'b1;
        b_m_data  = 64'h9;
        b_s_ready = 1'b1;
        tick;
        b_flush   = 1'b0;
        b_m_valid = 1'b0;
        check("fl_s_valid", b_s_valid, 0);
        check("fl_m_ready", b_m_ready, 1);
`ifdef AXI_SKID_FIFO_LEVEL_EN
        check("fl_level", b_level, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick;
            check("fl_no_stale", b_s_valid, 0);
        end
        b_m_valid = 1'b1;
        b_m_data  = 64'hB;
        tick;
        b_m_valid = 1'b0;
        check("fl_next_valid", b_s_valid, 1);
        check("fl_next_data", b_s_data, 64'hB);
        tick;
        check("fl_next_empty", b_s_valid, 0);

        // random traffic on DEPTH=2 against a queue scoreboard
        n_in = 0; n_out = 0; prev_stall = 1'b0; prev_data = '0;
        a_m_valid = 1'b0;
        for (int c = 0; c < 60000 && n_out < 10000; c++) begin
            if (!(a_m_valid && !a_m_ready)) begin
                a_m_valid = (n_in < 10000) && ($urandom_range(1, 0) == 1);
                a_m_data  = {$urandom, $urandom};
            end
            a_s_ready = ($urandom_range(1, 0) == 1);
            check("rnd_s_valid", a_s_valid, 64'(sb.size() > 0));
            check("rnd_m_ready", a_m_ready, 64'(sb.size() < 2));
`ifdef AXI_SKID_FIFO_LEVEL_EN
            check("rnd_level", a_level, 64'(sb.size()));
`endif
            if (prev_stall) check("rnd_hold", a_s_data, prev_data);
            prev_stall = a_s_valid && !a_s_ready;
            prev_data  = a_s_data;
            if (a_s_valid && a_s_ready && sb.size() > 0) begin
                check("rnd_data", a_s_data, sb[0]);
                void'(sb.pop_front());
                n_out++;
            end
            if (a_m_valid && a_m_ready) begin
                sb.push_back(a_m_data);
                n_in++;
            end
            tick;
        end
        a_m_valid = 1'b0;
        check("rnd_beats", 64'(n_out), 10000);

        // reset while two beats are stored
        a_s_ready = 1'b1;
        repeat (3) tick;
        a_s_ready = 1'b0;
        a_m_valid = 1'b1;
        a_m_data  = 64'h11;
        tick;
        a_m_data  = 64'h22;
        tick;
        a_m_valid = 1'b0;
        check("mr_pre_s_valid", a_s_valid, 1);
        rst = 1'b1;
        #1;
        check("mr_async_s_valid", a_s_valid, 0);
        check("mr_async_m_ready", a_m_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("mr_held_m_ready", a_m_ready, 0);
        tick;
        check("mr_release_m_ready", a_m_ready, 1);
        check("mr_release_s_valid", a_s_valid, 0);
        a_s_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("mr_no_stale", a_s_valid, 0);
        end
        a_m_valid = 1'b1;
        a_m_data  = 64'h33;
        tick;
        a_m_valid = 1'b0;
        check("mr_new_valid", a_s_valid, 1);
        check("mr_new_data", a_s_data, 64'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
